// File: rtl/or1200_pc_redirect_ctrl.sv
// or1200_pc_redirect_ctrl
// Arbitrates the PC redirect sources that feed or1200_genpc. The sources are
// SPR PC write, exception, EX branch/RFE and refetch. The block registers the
// winning word-address target and holds it until fetch accepts it. Branch
// redirects are deferred while the LSU is stalled. Same-cycle SPR/exception
// collisions and fetch acceptance timeouts raise sticky flags.
module or1200_pc_redirect_ctrl #(
  parameter logic [19:0] EXC_PREFIX_HI = 20'hF0000,
  parameter int          TIMEOUT       = 16,
  parameter int          TO_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spr_pc_we,
  input  logic [31:0] spr_dat_i,
  input  logic        except_start,
  input  logic [3:0]  except_type,
  input  logic        except_prefix,
  input  logic        ex_valid,
  input  logic [2:0]  branch_op,
  input  logic        flag,
  input  logic [29:0] ex_branch_addrtarget,
  input  logic [31:0] operand_b,
  input  logic [31:0] epcr,
  input  logic [29:0] pcreg,
  input  logic        genpc_refetch,
  input  logic        lsu_stall,
  input  logic        if_rdy,
  output logic        redir_valid,
  output logic [29:0] redir_pc,
  output logic [2:0]  redir_src,
  output logic        ex_branch_taken,
  output logic        wait_lsu,
  output logic        refetch_r,
  output logic        id_stall,
  output logic        coll_err,
  output logic        redir_timeout
);

  // Each state bit drives one output directly. Bit 1 is redir_valid and
  // bit 0 is wait_lsu.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_PEND = 2'b10;

  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_SPR  = 3'd1;
  localparam logic [2:0] SRC_EXC  = 3'd2;
  localparam logic [2:0] SRC_BR   = 3'd3;
  localparam logic [2:0] SRC_RFE  = 3'd4;
  localparam logic [2:0] SRC_REF  = 3'd5;

  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  logic [1:0]      r_state;
  logic [29:0]     r_pc;
  logic [2:0]      r_src;
  logic            r_ebt;
  logic            r_refetch;
  logic            r_coll;
  logic            r_timeout;
  logic [TO_W-1:0] r_cnt;

  logic            w_br_hit;
  logic            w_rfe_hit;
  logic [29:0]     w_br_pc;
  logic [29:0]     w_exc_pc;
  logic [2:0]      w_win_src;
  logic [29:0]     w_win_pc;
  logic            w_cap;
  logic [1:0]      w_nstate;
  logic [TO_W-1:0] w_cnt_inc;
  logic            w_unused_bits;

  // The low two bits of the byte-address sources are not used because all
  // targets are word addresses.
  assign w_unused_bits = ^{spr_dat_i[1:0], operand_b[1:0], epcr[1:0]};

  assign w_exc_pc  = {(except_prefix ? EXC_PREFIX_HI : 20'h00000), except_type, 6'h00};
  assign w_cnt_inc = (r_cnt == TO_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  // Decode the EX-stage branch opcode into taken-branch and RFE requests.
  always_comb begin
    w_br_hit  = 1'b0;
    w_rfe_hit = 1'b0;
    w_br_pc   = ex_branch_addrtarget;
    if (ex_valid) begin
      case (branch_op)
        3'd1, 3'd3: w_br_hit = 1'b1;
        3'd2: begin
          w_br_hit = 1'b1;
          w_br_pc  = operand_b[31:2];
        end
        3'd4:    w_br_hit  = flag;
        3'd5:    w_br_hit  = ~flag;
        3'd6:    w_rfe_hit = 1'b1;
        default: w_br_hit  = 1'b0;
      endcase
    end else begin
      w_br_hit  = 1'b0;
      w_rfe_hit = 1'b0;
    end
  end

  // Select the winning event by priority: SPR, then EXC, then BR/RFE, then REFETCH.
  always_comb begin
    w_win_src = SRC_NONE;
    w_win_pc  = r_pc;
    if (spr_pc_we) begin
      w_win_src = SRC_SPR;
      w_win_pc  = spr_dat_i[31:2];
    end else if (except_start) begin
      w_win_src = SRC_EXC;
      w_win_pc  = w_exc_pc;
    end else if (w_br_hit) begin
      w_win_src = SRC_BR;
      w_win_pc  = w_br_pc;
    end else if (w_rfe_hit) begin
      w_win_src = SRC_RFE;
      w_win_pc  = epcr[31:2];
    end else if (genpc_refetch) begin
      w_win_src = SRC_REF;
      w_win_pc  = pcreg;
    end else begin
      w_win_src = SRC_NONE;
      w_win_pc  = r_pc;
    end
  end

  // Compute the next state and decide whether the winner is captured this
  // edge. While a redirect is pending, ID is stalled, so only SPR and
  // exception events are accepted.
  always_comb begin
    w_cap    = 1'b0;
    w_nstate = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_win_src == SRC_NONE) begin
          w_nstate = ST_IDLE;
        end else if (((w_win_src == SRC_BR) || (w_win_src == SRC_RFE)) && lsu_stall) begin
          w_cap    = 1'b1;
          w_nstate = ST_WAIT;
        end else begin
          w_cap    = 1'b1;
          w_nstate = ST_PEND;
        end
      end
      ST_WAIT: begin
        if (spr_pc_we || except_start) begin
          w_cap    = 1'b1;
          w_nstate = ST_PEND;
        end else if (!lsu_stall) begin
          w_nstate = ST_PEND;
        end else begin
          w_nstate = ST_WAIT;
        end
      end
      ST_PEND: begin
        if (spr_pc_we || except_start) begin
          w_cap    = 1'b1;
          w_nstate = ST_PEND;
        end else if (if_rdy) begin
          w_nstate = ST_IDLE;
        end else begin
          w_nstate = ST_PEND;
        end
      end
      default: begin
        w_cap    = 1'b0;
        w_nstate = ST_IDLE;
      end
    endcase
  end

  // Update the state register, the held target and its source tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pc    <= 30'h0;
      r_src   <= SRC_NONE;
    end else begin
      r_state <= w_nstate;
      if (w_cap) begin
        r_pc  <= w_win_pc;
        r_src <= w_win_src;
      end else if (w_nstate == ST_IDLE) begin
        r_src <= SRC_NONE;
      end
    end
  end

  // Pulse outputs plus the sticky collision flag. The taken pulse marks the
  // capture of a branch, RFE or exception, not the release of a deferred branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ebt     <= 1'b0;
      r_refetch <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      r_ebt     <= w_cap && ((w_win_src == SRC_EXC) || (w_win_src == SRC_BR) ||
                             (w_win_src == SRC_RFE));
      r_refetch <= genpc_refetch;
      if (spr_pc_we && except_start) begin
        r_coll <= 1'b1;
      end
    end
  end

  // Saturating wait counter and sticky timeout flag for unaccepted redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_cap) begin
        r_cnt <= '0;
      end else if ((r_state == ST_PEND) && !if_rdy) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == TO_MAX) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign redir_valid     = r_state[1];
  assign wait_lsu        = r_state[0];
  assign id_stall        = r_state[1] | r_state[0];
  assign redir_pc        = r_pc;
  assign redir_src       = r_src;
  assign ex_branch_taken = r_ebt;
  assign refetch_r       = r_refetch;
  assign coll_err        = r_coll;
  assign redir_timeout   = r_timeout;

endmodule

// File: tb/tb_or1200_pc_redirect_ctrl.sv
// Directed bench for or1200_pc_redirect_ctrl. Expected values are hand-computed.
module tb_or1200_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        spr_pc_we;
  logic [31:0] spr_dat_i;
  logic        except_start;
  logic [3:0]  except_type;
  logic        except_prefix;
  logic        ex_valid;
  logic [2:0]  branch_op;
  logic        flag;
  logic [29:0] ex_branch_addrtarget;
  logic [31:0] operand_b;
  logic [31:0] epcr;
  logic [29:0] pcreg;
  logic        genpc_refetch;
  logic        lsu_stall;
  logic        if_rdy;
  logic        redir_valid;
  logic [29:0] redir_pc;
  logic [2:0]  redir_src;
  logic        ex_branch_taken;
  logic        wait_lsu;
  logic        refetch_r;
  logic        id_stall;
  logic        coll_err;
  logic        redir_timeout;

  int n_cmp = 0;
  int n_err = 0;

  or1200_pc_redirect_ctrl #(.EXC_PREFIX_HI(20'hF0000), .TIMEOUT(16), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .spr_pc_we(spr_pc_we), .spr_dat_i(spr_dat_i),
    .except_start(except_start), .except_type(except_type), .except_prefix(except_prefix),
    .ex_valid(ex_valid), .branch_op(branch_op), .flag(flag),
    .ex_branch_addrtarget(ex_branch_addrtarget), .operand_b(operand_b), .epcr(epcr),
    .pcreg(pcreg), .genpc_refetch(genpc_refetch), .lsu_stall(lsu_stall), .if_rdy(if_rdy),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_src(redir_src),
    .ex_branch_taken(ex_branch_taken), .wait_lsu(wait_lsu), .refetch_r(refetch_r),
    .id_stall(id_stall), .coll_err(coll_err), .redir_timeout(redir_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    spr_pc_we     = 1'b0;
    except_start  = 1'b0;
    ex_valid      = 1'b0;
    branch_op     = 3'd0;
    genpc_refetch = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_events();
    spr_dat_i = 32'h0; except_type = 4'h0; except_prefix = 1'b0; flag = 1'b0;
    ex_branch_addrtarget = 30'h0; operand_b = 32'h0; epcr = 32'h0; pcreg = 30'h0;
    lsu_stall = 1'b0; if_rdy = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_pc", {2'd0, redir_pc}, 32'd0);
    chk("rst_stall", {31'd0, id_stall}, 32'd0);
    chk("rst_flags", {28'd0, coll_err, redir_timeout, refetch_r, ex_branch_taken}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: BF taken
    ex_valid = 1'b1; branch_op = 3'd4; flag = 1'b1; ex_branch_addrtarget = 30'h100; if_rdy = 1'b1;
    tick();
    clear_events();
    chk("t1_valid", {31'd0, redir_valid}, 32'd1);
    chk("t1_pc", {2'd0, redir_pc}, 32'h100);
    chk("t1_src", {29'd0, redir_src}, 32'd3);
    chk("t1_ebt", {31'd0, ex_branch_taken}, 32'd1);
    tick();
    chk("t1_idle", {31'd0, redir_valid}, 32'd0);
    chk("t1_ebt_off", {31'd0, ex_branch_taken}, 32'd0);

    // BNF with flag=1 is not taken
    ex_valid = 1'b1; branch_op = 3'd5; flag = 1'b1;
    tick();
    clear_events();
    chk("bnf_nt", {30'd0, redir_valid, id_stall}, 32'd0);

    // RFE
    ex_valid = 1'b1; branch_op = 3'd6; epcr = 32'h0000_1007;
    tick();
    clear_events();
    chk("rfe_pc", {2'd0, redir_pc}, 32'h401);
    chk("rfe_src", {29'd0, redir_src}, 32'd4);
    tick();

    // 2: exception, fetch not ready for 3 cycles
    if_rdy = 1'b0;
    except_start = 1'b1; except_type = 4'h5; except_prefix = 1'b1;
    tick();
    clear_events();
    chk("t2_pc", {2'd0, redir_pc}, 32'h3C000140);
    chk("t2_src", {29'd0, redir_src}, 32'd2);
    chk("t2_ebt", {31'd0, ex_branch_taken}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_hold", {1'd0, id_stall, redir_pc}, {2'b01, 30'h3C000140});
    end
    if_rdy = 1'b1;
    tick();
    chk("t2_idle", {31'd0, redir_valid}, 32'd0);

    // 3: JR deferred behind lsu_stall
    ex_valid = 1'b1; branch_op = 3'd2; operand_b = 32'h2000; lsu_stall = 1'b1;
    tick();
    clear_events();
    chk("t3_ebt", {31'd0, ex_branch_taken}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_wait", {29'd0, wait_lsu, redir_valid, id_stall}, 32'b101);
      tick();
    end
    chk("t3_wait4", {29'd0, wait_lsu, redir_valid, id_stall}, 32'b101);
    lsu_stall = 1'b0;
    tick();
    chk("t3_pend", {30'd0, redir_valid, wait_lsu}, 32'b10);
    chk("t3_pc", {2'd0, redir_pc}, 32'h800);
    chk("t3_ebt_rel", {31'd0, ex_branch_taken}, 32'd0);
    tick();

    // 3b: exception overrides a deferred JR
    ex_valid = 1'b1; branch_op = 3'd2; lsu_stall = 1'b1;
    tick();
    clear_events();
    except_start = 1'b1; except_type = 4'h3; except_prefix = 1'b0;
    tick();
    clear_events();
    lsu_stall = 1'b0;
    chk("t3b_pc", {2'd0, redir_pc}, 32'hC0);
    chk("t3b_src", {29'd0, redir_src}, 32'd2);
    chk("t3b_state", {30'd0, redir_valid, wait_lsu}, 32'b10);
    tick();

    // 4: SPR and exception collide
    if_rdy = 1'b0;
    spr_pc_we = 1'b1; spr_dat_i = 32'h4000; except_start = 1'b1;
    tick();
    clear_events();
    chk("t4_pc", {2'd0, redir_pc}, 32'h1000);
    chk("t4_src", {29'd0, redir_src}, 32'd1);
    chk("t4_coll", {30'd0, coll_err, ex_branch_taken}, 32'b10);
    if_rdy = 1'b1;
    tick();
    chk("t4_sticky", {30'd0, coll_err, redir_valid}, 32'b10);

    // 5: timeout
    if_rdy = 1'b0;
    spr_pc_we = 1'b1; spr_dat_i = 32'h0000_0123;
    tick();
    clear_events();
    chk("t5_pc", {2'd0, redir_pc}, 32'h48);
    for (int i = 0; i < 15; i++) tick();
    chk("t5_not_yet", {31'd0, redir_timeout}, 32'd0);
    tick();
    chk("t5_timeout", {30'd0, redir_timeout, redir_valid}, 32'b11);
    if_rdy = 1'b1;
    tick();
    chk("t5_sticky", {30'd0, redir_timeout, redir_valid}, 32'b10);

    // 6: asynchronous reset mid-PEND
    if_rdy = 1'b0;
    spr_pc_we = 1'b1; spr_dat_i = 32'h8888;
    tick();
    clear_events();
    chk("t6_pend", {31'd0, redir_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_arst_pend", {2'd0, redir_pc}, 32'd0);
    chk("t6_arst_out", {26'd0, redir_valid, redir_src, coll_err, redir_timeout}, 32'd0);
    rst = 1'b1;
    tick();

    // asynchronous reset mid-WAIT_LSU
    ex_valid = 1'b1; branch_op = 3'd1; ex_branch_addrtarget = 30'h222; lsu_stall = 1'b1;
    tick();
    clear_events();
    chk("t6_wait", {31'd0, wait_lsu}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_arst_wait", {29'd0, wait_lsu, id_stall, ex_branch_taken}, 32'd0);
    rst = 1'b1;
    lsu_stall = 1'b0;
    tick();

    // refetch after reset release
    pcreg = 30'h0ABCDE; genpc_refetch = 1'b1;
    tick();
    clear_events();
    chk("t6_refr", {31'd0, refetch_r}, 32'd1);
    chk("t6_refpc", {2'd0, redir_pc}, 32'h0ABCDE);
    chk("t6_refsrc", {28'd0, ex_branch_taken, redir_src}, 32'd5);
    tick();
    chk("t6_refr_off", {31'd0, refetch_r}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
